rle_rx_decoder: RTL

//  Downstream stage of the run-length pixel encoder. Receives its serial frames on rxd, one bit
//  per clock: start(0), 8 data bits LSB first, stop(1); idle line is marking(1).

---
 rtl/rle_rx_decoder_if.sv | 22 ++
 rtl/rle_rx_decoder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/rle_rx_decoder_if.sv
// Pixel handshake between the RLE decoder and its consumer.
// dav_ is active low; rfd is the consumer's ready-for-data.
interface rle_pix_if;
  logic rfd;
  logic dav_;
  logic colore;
  logic endline;

  modport master (
    input  rfd,
    output dav_,
    output colore,
    output endline
  );

  modport slave (
    output rfd,
    input  dav_,
    input  colore,
    input  endline
  );
endinterface

// File: rtl/rle_rx_decoder.sv
// Serial RLE token receiver, token FIFO and run expander.
// Tokens: D[0] colour, D[7:1] run length, 8'h00 end-of-line.
module rle_rx_decoder #(
  parameter int FIFO_AW = 2
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      rxd,
  rle_pix_if.master px,
  output logic      frame_err,
  output logic      ovf_err
);
  localparam int FIFO_DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {
    R_IDLE,
    R_DATA,
    R_STOP
  } rx_st_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_WAIT,
    P_ACK
  } px_st_t;

  rx_st_t r_st, r_nxt;
  px_st_t p_st, p_nxt;

  logic [7:0] sr;
  logic [2:0] bc;
  logic       push;
  logic       ferr_set;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [FIFO_AW:0] wp, rp;
  logic             empty, full;
  logic             pop, wr_ok;
  logic [7:0]       tok;

  logic [6:0] rc;
  logic       col, eol;
  logic       dav_q, col_q, eol_q;

  // Receive FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_st <= R_IDLE;
    else       r_st <= r_nxt;
  end

  always_comb begin
    r_nxt    = r_st;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (r_st)
      R_IDLE: if (!rxd) r_nxt = R_DATA;
      R_DATA: if (bc == 3'd7) r_nxt = R_STOP;
      R_STOP: begin
        r_nxt = R_IDLE;
        if (rxd) push = (sr != 8'h01);
        else     ferr_set = 1'b1;
      end
      default: r_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr <= 8'h00;
      bc <= 3'd0;
    end else if (r_st == R_IDLE) begin
      bc <= 3'd0;
    end else if (r_st == R_DATA) begin
      sr <= {rxd, sr[7:1]};
      bc <= bc + 3'd1;
    end
  end

  // Token FIFO; a push into a full FIFO still fits if a pop frees a slot
  assign empty = (wp == rp);
  assign full  = (wp[FIFO_AW] != rp[FIFO_AW]) &&
                 (wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0]);
  assign wr_ok = push && (!full || pop);
  assign tok   = mem[rp[FIFO_AW-1:0]];

  always_ff @(posedge clock) begin
    if (wr_ok) mem[wp[FIFO_AW-1:0]] <= sr;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp        <= '0;
      rp        <= '0;
      frame_err <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (pop)   rp <= rp + 1'b1;
      if (ferr_set) frame_err <= 1'b1;
      if (push && !wr_ok) ovf_err <= 1'b1;
    end
  end

  // Pixel FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) p_st <= P_IDLE;
    else       p_st <= p_nxt;
  end

  always_comb begin
    p_nxt = p_st;
    pop   = 1'b0;
    unique case (p_st)
      P_IDLE: if (!empty) begin
        pop   = 1'b1;
        p_nxt = P_WAIT;
      end
      P_WAIT: if (px.rfd) p_nxt = P_ACK;
      P_ACK: if (!px.rfd) begin
        if (eol || rc == 7'd1) p_nxt = P_IDLE;
        else                   p_nxt = P_WAIT;
      end
      default: p_nxt = P_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rc    <= 7'd0;
      col   <= 1'b0;
      eol   <= 1'b0;
      dav_q <= 1'b1;
      col_q <= 1'b0;
      eol_q <= 1'b0;
    end else begin
      if (pop) begin
        rc  <= tok[7:1];
        col <= tok[0];
        eol <= (tok == 8'h00);
      end
      if (p_st == P_WAIT && px.rfd) begin
        dav_q <= 1'b0;
        col_q <= col & ~eol;
        eol_q <= eol;
      end
      if (p_st == P_ACK && !px.rfd) begin
        dav_q <= 1'b1;
        if (!(eol || rc == 7'd1)) rc <= rc - 7'd1;
      end
    end
  end

  assign px.dav_    = dav_q;
  assign px.colore  = col_q;
  assign px.endline = eol_q;
endmodule
